// File: rtl/cluster_dma_pkg.sv
// Shared types and constants for the cluster DMA 2D midend and its neighbours.
package cluster_dma_pkg;

  // Default widths used by the request structs exchanged with the frontend/backend.
  localparam int unsigned DmaAddrWidth     = 32;
  localparam int unsigned DmaNumBytesWidth = 32;
  localparam int unsigned DmaRepWidth      = 16;
  localparam int unsigned FlagsWidth       = 3;

  // Bit positions inside the {deburst, decouple, serialize} flag vector.
  localparam int unsigned DeburstBit   = 2;
  localparam int unsigned DecoupleBit  = 1;
  localparam int unsigned SerializeBit = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } twod_state_e;

  typedef struct packed {
    logic [DmaAddrWidth-1:0]     src;
    logic [DmaAddrWidth-1:0]     dst;
    logic [DmaNumBytesWidth-1:0] num_bytes;
    logic [DmaAddrWidth-1:0]     src_stride;
    logic [DmaAddrWidth-1:0]     dst_stride;
    logic [DmaRepWidth-1:0]      num_reps;
    logic [FlagsWidth-1:0]       flags;
  } twod_req_t;

  typedef struct packed {
    logic [DmaAddrWidth-1:0]     src;
    logic [DmaAddrWidth-1:0]     dst;
    logic [DmaNumBytesWidth-1:0] num_bytes;
    logic [FlagsWidth-1:0]       flags;
    logic                        last;
  } oned_req_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO. A pop frees its slot in the same cycle, so a push
// into a full FIFO is accepted when a pop happens alongside it.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Read/write pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/cluster_dma_twod_midend.sv
// Splits a 2D strided DMA descriptor into a sequence of 1D row bursts and
// collapses the per-row backend retirements into one completion per 2D job.
//
//   state | meaning
//   IDLE  | no rows to issue; ready for a new descriptor if a completion slot is free
//   ISSUE | presenting the current row on oned_*; ready only on the final-row handshake
module cluster_dma_twod_midend
  import cluster_dma_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned RepWidth      = 16,
  parameter int unsigned CmplFifoDepth = 4,
  parameter int unsigned NumBytesWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     twod_valid_i,
  output logic                     twod_ready_o,
  input  logic [AddrWidth-1:0]     twod_src_i,
  input  logic [AddrWidth-1:0]     twod_dst_i,
  input  logic [NumBytesWidth-1:0] twod_num_bytes_i,
  input  logic [AddrWidth-1:0]     twod_src_stride_i,
  input  logic [AddrWidth-1:0]     twod_dst_stride_i,
  input  logic [RepWidth-1:0]      twod_num_reps_i,
  input  logic [FlagsWidth-1:0]    twod_flags_i,
  output logic                     oned_valid_o,
  input  logic                     oned_ready_i,
  output logic [AddrWidth-1:0]     oned_src_o,
  output logic [AddrWidth-1:0]     oned_dst_o,
  output logic [NumBytesWidth-1:0] oned_num_bytes_o,
  output logic [FlagsWidth-1:0]    oned_flags_o,
  output logic                     oned_last_o,
  input  logic                     trans_complete_i,
  output logic                     twod_complete_o,
  output logic                     busy_o
);

  twod_state_e              state_q;
  logic [AddrWidth-1:0]     src_q, dst_q, src_stride_q, dst_stride_q;
  logic [NumBytesWidth-1:0] num_bytes_q;
  logic [FlagsWidth-1:0]    flags_q;
  logic [RepWidth-1:0]      rem_q;
  logic [RepWidth:0]        retire_cnt_q;
  logic                     twod_complete_q;

  logic [RepWidth-1:0]      reps_eff;
  logic [RepWidth:0]        retire_sum, fifo_head;
  logic                     fifo_full, fifo_empty, cmpl_pop;
  logic                     twod_hs, oned_hs, final_hs, slot_free;

  // A zero repetition count still moves one row.
  assign reps_eff = (twod_num_reps_i == '0) ? RepWidth'(1) : twod_num_reps_i;

  assign oned_hs   = oned_valid_o & oned_ready_i;
  assign final_hs  = oned_hs & (rem_q == RepWidth'(1));
  // The retiring job's slot is reusable in the cycle it pops.
  assign slot_free = ~fifo_full | cmpl_pop;

  assign twod_ready_o = slot_free & ((state_q == IDLE) | final_hs);
  assign twod_hs      = twod_valid_i & twod_ready_o;

  assign oned_valid_o     = (state_q == ISSUE);
  assign oned_src_o       = src_q;
  assign oned_dst_o       = dst_q;
  assign oned_num_bytes_o = num_bytes_q;
  assign oned_flags_o     = flags_q;
  assign oned_last_o      = (state_q == ISSUE) & (rem_q == RepWidth'(1));

  assign retire_sum = retire_cnt_q + {{RepWidth{1'b0}}, trans_complete_i};
  assign cmpl_pop   = ~fifo_empty & (retire_sum == fifo_head);

  assign twod_complete_o = twod_complete_q;
  assign busy_o          = (state_q == ISSUE) | ~fifo_empty;

  // Row count of every accepted job, oldest first.
  fifo_v3 #(
    .DATA_WIDTH (RepWidth + 1),
    .DEPTH      (CmplFifoDepth)
  ) i_cmpl_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (twod_hs),
    .data_i  ({1'b0, reps_eff}),
    .pop_i   (cmpl_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue FSM and row address generator; a new descriptor always wins over
  // advancing because acceptance in ISSUE only happens on the final row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      num_bytes_q  <= '0;
      flags_q      <= '0;
      rem_q        <= '0;
    end else if (twod_hs) begin
      state_q      <= ISSUE;
      src_q        <= twod_src_i;
      dst_q        <= twod_dst_i;
      src_stride_q <= twod_src_stride_i;
      dst_stride_q <= twod_dst_stride_i;
      num_bytes_q  <= twod_num_bytes_i;
      flags_q      <= twod_flags_i;
      rem_q        <= reps_eff;
    end else if (oned_hs) begin
      if (rem_q == RepWidth'(1)) begin
        state_q <= IDLE;
      end else begin
        src_q <= src_q + src_stride_q;
        dst_q <= dst_q + dst_stride_q;
        rem_q <= rem_q - RepWidth'(1);
      end
    end
  end

  // Retirement counter for the oldest job and registered completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_q    <= '0;
      twod_complete_q <= 1'b0;
    end else begin
      twod_complete_q <= cmpl_pop;
      if (cmpl_pop) begin
        retire_cnt_q <= '0;
      end else if (trans_complete_i && !fifo_empty) begin
        retire_cnt_q <= retire_sum;
      end
    end
  end

  // The backend must never retire a burst that belongs to no tracked job.
  a_no_orphan_retire: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(trans_complete_i && fifo_empty));

endmodule

// File: tb/tb_cluster_dma_twod_midend.sv
// Randomised bench for the 2D midend with a row/job level reference model.
module tb_cluster_dma_twod_midend;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        twod_valid_i;
  logic        twod_ready_o;
  logic [31:0] twod_src_i, twod_dst_i, twod_num_bytes_i;
  logic [31:0] twod_src_stride_i, twod_dst_stride_i;
  logic [15:0] twod_num_reps_i;
  logic [2:0]  twod_flags_i;
  logic        oned_valid_o, oned_ready_i;
  logic [31:0] oned_src_o, oned_dst_o, oned_num_bytes_o;
  logic [2:0]  oned_flags_o;
  logic        oned_last_o;
  logic        trans_complete_i;
  logic        twod_complete_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  cluster_dma_twod_midend #(
    .AddrWidth     (32),
    .RepWidth      (16),
    .CmplFifoDepth (DEPTH),
    .NumBytesWidth (32)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .twod_valid_i      (twod_valid_i),
    .twod_ready_o      (twod_ready_o),
    .twod_src_i        (twod_src_i),
    .twod_dst_i        (twod_dst_i),
    .twod_num_bytes_i  (twod_num_bytes_i),
    .twod_src_stride_i (twod_src_stride_i),
    .twod_dst_stride_i (twod_dst_stride_i),
    .twod_num_reps_i   (twod_num_reps_i),
    .twod_flags_i      (twod_flags_i),
    .oned_valid_o      (oned_valid_o),
    .oned_ready_i      (oned_ready_i),
    .oned_src_o        (oned_src_o),
    .oned_dst_o        (oned_dst_o),
    .oned_num_bytes_o  (oned_num_bytes_o),
    .oned_flags_o      (oned_flags_o),
    .oned_last_o       (oned_last_o),
    .trans_complete_i  (trans_complete_i),
    .twod_complete_o   (twod_complete_o),
    .busy_o            (busy_o)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Reference model: every accepted job expands into its full list of rows,
  // and each job remembers how many retirements it needs.
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] nb;
    logic [2:0]  fl;
    logic        last;
  } row_t;

  row_t        rows_q[$];
  int unsigned jobs_tot[$];
  int unsigned head_ret = 0, outstanding = 0, cmpl_seen = 0, cyc = 0;
  int unsigned last_acc_cyc = 0, last_pop_cyc = 0;
  bit          cmpl_due = 0, acc_flag = 0, hold_vld = 0;
  row_t        held;
  logic [31:0] log_src[$], log_dst[$];
  bit          log_last[$];
  int unsigned log_cyc[$];

  int          rdy_mode = 1;
  bit          ret_en = 0;
  int          ret_pct = 100;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      int unsigned pend, n;
      bit          pop_now, exp_ready;
      row_t        r;
      pend = rows_q.size();
      chk("oned_valid", 64'(oned_valid_o), 64'(pend > 0));
      chk("busy", 64'(busy_o), 64'(pend > 0 || jobs_tot.size() > 0));
      chk("twod_complete", 64'(twod_complete_o), 64'(cmpl_due));
      if (twod_complete_o) cmpl_seen++;
      cmpl_due = 0;
      pop_now = (jobs_tot.size() > 0) && trans_complete_i && (head_ret + 1 == jobs_tot[0]);
      exp_ready = (pend == 0 || (pend == 1 && oned_ready_i)) &&
                  (jobs_tot.size() < DEPTH || pop_now);
      chk("twod_ready", 64'(twod_ready_o), 64'(exp_ready));
      if (hold_vld && oned_valid_o) begin
        chk("hold_src", 64'(oned_src_o), 64'(held.src));
        chk("hold_dst", 64'(oned_dst_o), 64'(held.dst));
        chk("hold_bytes", 64'(oned_num_bytes_o), 64'(held.nb));
        chk("hold_last", 64'(oned_last_o), 64'(held.last));
      end
      hold_vld = oned_valid_o && !oned_ready_i;
      held = '{src: oned_src_o, dst: oned_dst_o, nb: oned_num_bytes_o,
               fl: oned_flags_o, last: oned_last_o};
      if (oned_valid_o && oned_ready_i) begin
        chk("row_expected", 64'(pend > 0), 64'(1));
        if (pend > 0) begin
          r = rows_q.pop_front();
          chk("row_src", 64'(oned_src_o), 64'(r.src));
          chk("row_dst", 64'(oned_dst_o), 64'(r.dst));
          chk("row_bytes", 64'(oned_num_bytes_o), 64'(r.nb));
          chk("row_flags", 64'(oned_flags_o), 64'(r.fl));
          chk("row_last", 64'(oned_last_o), 64'(r.last));
          outstanding++;
          log_src.push_back(oned_src_o);
          log_dst.push_back(oned_dst_o);
          log_last.push_back(oned_last_o);
          log_cyc.push_back(cyc);
        end
      end
      if (trans_complete_i) begin
        if (jobs_tot.size() > 0) begin
          head_ret++;
          if (head_ret == jobs_tot[0]) begin
            void'(jobs_tot.pop_front());
            head_ret = 0;
            cmpl_due = 1;
            last_pop_cyc = cyc;
          end
        end
        if (outstanding > 0) outstanding--;
      end
      if (twod_valid_i && twod_ready_o) begin
        n = (twod_num_reps_i == 16'd0) ? 1 : 32'(twod_num_reps_i);
        for (int k = 0; k < int'(n); k++) begin
          rows_q.push_back('{src: twod_src_i + twod_src_stride_i * 32'(k),
                             dst: twod_dst_i + twod_dst_stride_i * 32'(k),
                             nb: twod_num_bytes_i, fl: twod_flags_i,
                             last: (k == int'(n) - 1)});
        end
        jobs_tot.push_back(n);
        acc_flag = 1;
        last_acc_cyc = cyc;
      end
      cyc++;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    case (rdy_mode)
      0:       oned_ready_i = 1'b0;
      1:       oned_ready_i = 1'b1;
      default: oned_ready_i = 1'($urandom_range(0, 1));
    endcase
    trans_complete_i = ret_en && outstanding > 0 && ($urandom_range(0, 99) < ret_pct);
  endtask

  task automatic set_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] nb,
                         input logic [31:0] ss, input logic [31:0] ds,
                         input logic [15:0] reps, input logic [2:0] fl);
    twod_src_i = s; twod_dst_i = d; twod_num_bytes_i = nb;
    twod_src_stride_i = ss; twod_dst_stride_i = ds;
    twod_num_reps_i = reps; twod_flags_i = fl;
    twod_valid_i = 1'b1;
    acc_flag = 0;
  endtask

  task automatic wait_acc(input int bound);
    int k = 0;
    while (!acc_flag && k < bound) begin
      step();
      k++;
    end
    chk("accept_timeout", 64'(acc_flag), 64'(1));
    twod_valid_i = 1'b0;
  endtask

  task automatic send_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] nb,
                          input logic [31:0] ss, input logic [31:0] ds,
                          input logic [15:0] reps, input logic [2:0] fl);
    set_job(s, d, nb, ss, ds, reps, fl);
    wait_acc(300);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((rows_q.size() > 0 || jobs_tot.size() > 0 || cmpl_due) && k < bound) begin
      step();
      k++;
    end
    chk("drain_timeout", 64'(k < bound), 64'(1));
  endtask

  task automatic clear_log();
    log_src.delete(); log_dst.delete(); log_last.delete(); log_cyc.delete();
  endtask

  int unsigned c0;

  initial begin
    rst_ni = 1'b0;
    twod_valid_i = 1'b0;
    set_job(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0, 3'h0);
    twod_valid_i = 1'b0;
    oned_ready_i = 1'b0;
    trans_complete_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(twod_ready_o), 64'(1));
    chk("rst_valid", 64'(oned_valid_o), 64'(0));
    chk("rst_src", 64'(oned_src_o), 64'(0));
    chk("rst_last", 64'(oned_last_o), 64'(0));
    chk("rst_cmpl", 64'(twod_complete_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    rst_ni = 1'b1;
    step();

    // Single 3-row job on an always-ready backend.
    rdy_mode = 1; ret_en = 0; clear_log(); c0 = cmpl_seen;
    send_job(32'h1000, 32'h8000, 32'd64, 32'h100, 32'h40, 16'd3, 3'b000);
    repeat (5) step();
    chk("t1_rows", 64'(log_src.size()), 64'(3));
    chk("t1_src0", 64'(log_src[0]), 64'(32'h1000));
    chk("t1_src1", 64'(log_src[1]), 64'(32'h1100));
    chk("t1_src2", 64'(log_src[2]), 64'(32'h1200));
    chk("t1_dst1", 64'(log_dst[1]), 64'(32'h8040));
    chk("t1_dst2", 64'(log_dst[2]), 64'(32'h8080));
    chk("t1_last", 64'({log_last[0], log_last[1], log_last[2]}), 64'(3'b001));
    chk("t1_consecutive", 64'(log_cyc[2] - log_cyc[0]), 64'(2));
    chk("t1_no_early_cmpl", 64'(cmpl_seen - c0), 64'(0));
    ret_en = 1; ret_pct = 100;
    drain(100);
    chk("t1_cmpl", 64'(cmpl_seen - c0), 64'(1));

    // reps = 0 and reps = 1 both move exactly one row.
    for (int i = 0; i < 2; i++) begin
      clear_log(); c0 = cmpl_seen;
      send_job(32'h2000, 32'h3000, 32'd8, 32'h10, 32'h10, 16'(i), 3'b101);
      drain(100);
      chk("r01_rows", 64'(log_src.size()), 64'(1));
      chk("r01_last", 64'(log_last[0]), 64'(1));
      chk("r01_cmpl", 64'(cmpl_seen - c0), 64'(1));
    end

    // Random backpressure over a 4-row job.
    rdy_mode = 2; ret_pct = 50; clear_log(); c0 = cmpl_seen;
    send_job(32'h4000, 32'h5000, 32'd32, 32'h20, 32'h80, 16'd4, 3'b010);
    drain(300);
    chk("bp_rows", 64'(log_src.size()), 64'(4));
    chk("bp_cmpl", 64'(cmpl_seen - c0), 64'(1));

    // Back-to-back: second job taken on the first job's last-row handshake.
    rdy_mode = 1; ret_en = 0; clear_log(); c0 = cmpl_seen;
    send_job(32'hA000, 32'hB000, 32'd16, 32'h10, 32'h10, 16'd2, 3'b000);
    send_job(32'hC000, 32'hD000, 32'd16, 32'h10, 32'h10, 16'd3, 3'b000);
    chk("b2b_accept_on_last", 64'(last_acc_cyc), 64'(log_cyc[1]));
    repeat (4) step();
    chk("b2b_no_gap", 64'(log_cyc[2] - log_cyc[1]), 64'(1));
    chk("b2b_next_src", 64'(log_src[2]), 64'(32'hC000));
    ret_en = 1; ret_pct = 100;
    drain(100);
    chk("b2b_cmpl", 64'(cmpl_seen - c0), 64'(2));

    // Completion FIFO full: third job waits for the oldest job to retire.
    ret_en = 0; clear_log(); c0 = cmpl_seen;
    send_job(32'h100, 32'h200, 32'd4, 32'h4, 32'h4, 16'd2, 3'b000);
    send_job(32'h300, 32'h400, 32'd4, 32'h4, 32'h4, 16'd2, 3'b000);
    set_job(32'h500, 32'h600, 32'd4, 32'h4, 32'h4, 16'd1, 3'b000);
    repeat (8) step();
    chk("full_stall", 64'(acc_flag), 64'(0));
    ret_en = 1; ret_pct = 100;
    wait_acc(50);
    chk("full_pop_accept", 64'(last_acc_cyc), 64'(last_pop_cyc));
    drain(100);
    chk("full_cmpl", 64'(cmpl_seen - c0), 64'(3));

    // Address wrap and negative stride.
    clear_log();
    send_job(32'hFFFF_FFF0, 32'h100, 32'd16, 32'h20, 32'hFFFF_FFC0, 16'd3, 3'b000);
    drain(100);
    chk("wrap_src1", 64'(log_src[1]), 64'(32'h10));
    chk("wrap_src2", 64'(log_src[2]), 64'(32'h30));
    chk("neg_dst1", 64'(log_dst[1]), 64'(32'hC0));
    chk("neg_dst2", 64'(log_dst[2]), 64'(32'h80));

    // Reset in the middle of a job drops everything.
    ret_en = 0;
    send_job(32'h7000, 32'h9000, 32'd64, 32'h40, 32'h40, 16'd6, 3'b000);
    repeat (2) step();
    chk("pre_rst_valid", 64'(oned_valid_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(oned_valid_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_ready", 64'(twod_ready_o), 64'(1));
    rows_q.delete(); jobs_tot.delete();
    head_ret = 0; outstanding = 0; cmpl_due = 0; hold_vld = 0;
    c0 = cmpl_seen;
    repeat (3) step();
    rst_ni = 1'b1;
    ret_en = 1;
    repeat (15) step();
    chk("post_rst_no_cmpl", 64'(cmpl_seen - c0), 64'(0));
    chk("post_rst_busy", 64'(busy_o), 64'(0));

    // Randomised jobs with random backpressure and retirement timing.
    rdy_mode = 2; ret_en = 1; ret_pct = 50; c0 = cmpl_seen;
    for (int j = 0; j < 25; j++) begin
      send_job($urandom, $urandom, 32'($urandom_range(0, 256)), $urandom, $urandom,
               16'($urandom_range(0, 5)), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) step();
    end
    drain(3000);
    chk("rand_cmpl", 64'(cmpl_seen - c0), 64'(25));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_dma_twod_midend.md
Name: cluster_dma_twod_midend

Overview:
- Sequencer between the cluster DMA frontend arbiter and one 1D AXI DMA backend stream.
- Accepts a 2D (strided) transfer descriptor and issues num_reps 1D burst requests with per-repetition source/destination stride increments.
- Tracks backend retirements in order and emits a single completion pulse per 2D transfer, so the transfer-ID counters count 2D jobs rather than rows.

Parameters:
- AddrWidth, 32, width of src/dst addresses and strides.
- RepWidth, 16, width of the repetition counter.
- CmplFifoDepth, 4, number of accepted 2D jobs whose completion can be tracked at once; must be >= 1.
- NumBytesWidth, 32, width of the 1D length field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- twod_valid_i  in  1  2D descriptor valid
- twod_ready_o  out  1  2D descriptor accept
- twod_src_i  in  AddrWidth  first-row source address
- twod_dst_i  in  AddrWidth  first-row destination address
- twod_num_bytes_i  in  NumBytesWidth  bytes per row
- twod_src_stride_i  in  AddrWidth  source increment per row
- twod_dst_stride_i  in  AddrWidth  destination increment per row
- twod_num_reps_i  in  RepWidth  row count; 0 is treated as 1
- twod_flags_i  in  3  {deburst, decouple, serialize}
- oned_valid_o  out  1  1D burst valid to backend
- oned_ready_i  in  1  backend accept
- oned_src_o  out  AddrWidth  row source address
- oned_dst_o  out  AddrWidth  row destination address
- oned_num_bytes_o  out  NumBytesWidth  row length
- oned_flags_o  out  3  flags, passed through unchanged
- oned_last_o  out  1  current row is the final row of its job
- trans_complete_i  in  1  backend retired one 1D burst (single-cycle pulse, in order)
- twod_complete_o  out  1  single-cycle pulse: all rows of the oldest job have retired
- busy_o  out  1  issuing rows or completions still outstanding

Behaviour:
- Reset values: twod_ready_o=1, oned_valid_o=0, oned_* data=0, oned_last_o=0, twod_complete_o=0, busy_o=0. The FSM enters IDLE, the completion FIFO is empty and the retire counter is 0.
- Reset mid-operation drops all in-flight state. No completion is ever emitted for a job that was accepted before the reset.
- FSM IDLE:
  - twod_ready_o = !cmpl_fifo_full.
  - On handshake: latch the descriptor into registers, rem_q = max(num_reps,1), push rem_q into the completion FIFO, go to ISSUE.
  - oned_valid_o rises in the cycle after acceptance, giving 1-cycle latency.
- FSM ISSUE:
  - oned_valid_o=1 and oned_* come from registers only; they are held stable while valid && !ready.
  - oned_last_o = (rem_q==1).
  - On oned handshake with rem_q>1: src_q += src_stride, dst_q += dst_stride, rem_q -= 1. Additions wrap mod 2^AddrWidth with no carry out, so negative strides work in two's complement.
  - On oned handshake with rem_q==1: the job is done.
    - twod_ready_o is asserted combinationally in that same cycle when the FIFO is not full, allowing back-to-back acceptance.
    - If a new descriptor is accepted that cycle, load it and stay in ISSUE with no bubble.
    - Otherwise go to IDLE.
  - twod_ready_o=0 in ISSUE except in that final-handshake cycle.
- Completion tracking:
  - retire_cnt_q (RepWidth+1 bits) increments on each trans_complete_i.
  - When the FIFO is non-empty and retire_cnt_q + trans_complete_i == head: pop, pulse twod_complete_o for 1 cycle, and set retire_cnt_q = 0.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - A pop frees the slot in that cycle, so twod_ready_o may depend on it (pop-before-push).
  - trans_complete_i with an empty FIFO is a protocol error: assertion, counter ignored.
- busy_o = (state==ISSUE) | !cmpl_fifo_empty.
- num_bytes==0 rows are issued unchanged; the backend defines their retirement.
- The flags and num_bytes of a job are constant across its rows.

Decomposition:
- Package cluster_dma_pkg holds:
  - twod_req_t and oned_req_t packed structs (addr, num_bytes, strides, reps, flags);
  - flag bit indices DeburstBit=2, DecoupleBit=1, SerializeBit=0.
- Sub-module: the completion FIFO is an instance of the common fifo_v3 (DATA_WIDTH=RepWidth+1, DEPTH=CmplFifoDepth). The FSM, address generator and retire counter stay in the top module.

Test Plan:
- Single 2D job, src=0x1000, dst=0x8000, bytes=64, strides 0x100/0x40, reps=3, oned_ready_i=1:
  - rows (0x1000,0x8000), (0x1100,0x8040), (0x1200,0x8080) on consecutive cycles, oned_last_o only on the third;
  - after 3 trans_complete_i pulses, exactly one twod_complete_o.
- reps=0 and reps=1 each produce exactly one row with oned_last_o=1 and one completion after one retire.
- Backpressure: oned_ready_i toggles randomly while reps=4 → oned_* stable whenever valid&&!ready; exactly 4 rows issued in order.
- Back-to-back: a second job is offered during the last-row handshake of the first → accepted that cycle, next row is the second job's first row on the following cycle with no gap. Completions arrive in order, 2 pulses total.
- CmplFifoDepth=2 with trans_complete_i held low: third descriptor stalls (twod_ready_o=0). Retiring all rows of job 1 → pop and same-cycle acceptance of job 3.
- Wrap and reset:
  - src=0xFFFF_FFF0 with stride 0x20 yields next src 0x0000_0010;
  - stride 0xFFFF_FFC0 decrements by 0x40;
  - rst_ni asserted mid-job clears oned_valid_o and busy_o immediately, and no twod_complete_o follows.
